// File: rtl/apb_sram_slave.sv
// APB3 slave around a word-addressed scratch RAM with programmable wait states.
// The RAM is zero-filled word by word after every reset; bad addresses answer with PSLVERR.
module apb_sram_slave #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter int unsigned           EXTRA_WAIT = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned           LANES      = DATA_WIDTH / 8;
    localparam int unsigned           OFF_BITS   = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int unsigned           IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(LANES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DEPTH - 1);
    // WAIT is entered one cycle into the access, so it needs one count fewer than EXTRA_WAIT.
    localparam logic [3:0]            WAIT_LOAD  = (EXTRA_WAIT > 0) ? 4'(EXTRA_WAIT - 1) : 4'd0;
    localparam bit                    NO_WAIT    = (EXTRA_WAIT == 0);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        init_cnt_r, init_cnt_s;
    logic [3:0]              wait_cnt_r, wait_cnt_s;
    logic                    pready_r, pready_s;
    logic                    pslverr_r, pslverr_s;
    logic [DATA_WIDTH-1:0]   prdata_r, prdata_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    access_s;
    logic                    complete_s;
    logic                    err_s;
    logic [ADDR_WIDTH-1:0]   offset_s;
    logic [ADDR_WIDTH-1:0]   word_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    mem_we_s;
    logic [IDX_W-1:0]        mem_idx_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    // Address decode and error classification.
    always_comb begin
        access_s = PSEL & PENABLE;
        offset_s = PADDR - BASE_ADDR;
        word_s   = offset_s >> OFF_BITS;
        idx_s    = word_s[IDX_W-1:0];
        err_s    = (PADDR < BASE_ADDR) | ((offset_s & ALIGN_MASK) != {ADDR_WIDTH{1'b0}})
                 | (word_s >= DEPTH_A);
    end

    // Next-state, response and memory-port logic.
    always_comb begin
        state_s     = state_r;
        init_cnt_s  = init_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        pready_s    = 1'b0;
        pslverr_s   = 1'b0;
        prdata_s    = prdata_r;
        mem_we_s    = 1'b0;
        mem_idx_s   = {IDX_W{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        complete_s  = 1'b0;

        case (state_r)
            ST_INIT: begin
                mem_we_s  = 1'b1;
                mem_idx_s = init_cnt_r;
                if (init_cnt_r == LAST_IDX) begin
                    state_s    = ST_IDLE;
                    init_cnt_s = {IDX_W{1'b0}};
                end else begin
                    init_cnt_s = init_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (access_s && NO_WAIT) begin
                    complete_s = 1'b1;
                end else if (access_s) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = WAIT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!access_s) begin
                    state_s = ST_IDLE;
                end else if (wait_cnt_r == 4'd0) begin
                    complete_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase

        if (complete_s) begin
            state_s   = ST_RESP;
            pready_s  = 1'b1;
            pslverr_s = err_s;
            if (PWRITE && !err_s) begin
                mem_we_s    = 1'b1;
                mem_idx_s   = idx_s;
                mem_wdata_s = PWDATA;
            end else if (PWRITE) begin
                mem_we_s = 1'b0;
            end else if (err_s) begin
                prdata_s = {DATA_WIDTH{1'b0}};
            end else begin
                prdata_s = mem_r[idx_s];
            end
        end else begin
            pready_s = 1'b0;
        end
    end

    // State and registered APB outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {IDX_W{1'b0}};
            wait_cnt_r <= 4'd0;
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
            prdata_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            pready_r   <= pready_s;
            pslverr_r  <= pslverr_s;
            prdata_r   <= prdata_s;
        end
    end

    // RAM write port; a write landing on a reset edge is dropped.
    always_ff @(posedge PCLK) begin
        if (mem_we_s && !PRESET) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign PRDATA  = prdata_r;
    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Self-checking bench: two slaves (EXTRA_WAIT=2 and EXTRA_WAIT=0) checked against an array model.
module tb_apb_sram_slave;

    localparam int          DEPTH = 16;
    localparam int          EW    = 2;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel2, penable2, pwrite2, pready2, pslverr2;
    logic [31:0] paddr2, pwdata2, prdata2;
    logic        psel0, penable0, pwrite0, pready0, pslverr0;
    logic [31:0] paddr0, pwdata0, prdata0;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ref2 [DEPTH];
    logic [31:0] ref0 [DEPTH];

    apb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                     .EXTRA_WAIT(EW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel2), .PENABLE(penable2), .PWRITE(pwrite2),
        .PADDR(paddr2), .PWDATA(pwdata2), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));

    apb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                     .EXTRA_WAIT(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0),
        .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    always #5 PCLK = ~PCLK;

    function automatic bit addr_err(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        if (((a - BASE) % 4) != 0) return 1'b1;
        return ((a - BASE) / 4) >= DEPTH;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            ref2[i] = 32'h0;
            ref0[i] = 32'h0;
        end
    endtask

    task automatic drive(input bit d0, input bit sel, input bit en, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (d0) begin
            psel0 = sel; penable0 = en; pwrite0 = wr; paddr0 = addr; pwdata0 = wd;
        end else begin
            psel2 = sel; penable2 = en; pwrite2 = wr; paddr2 = addr; pwdata2 = wd;
        end
    endtask

    // One full APB transfer; lat = access cycle in which PREADY was seen, -1 if never.
    task automatic xfer(input bit d0, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge PCLK); drive(d0, 1'b1, 1'b0, wr, addr, wd);
        @(negedge PCLK); drive(d0, 1'b1, 1'b1, wr, addr, wd);
        lat = -1; rd = 32'hx; err = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge PCLK); #1;
            if (d0 ? pready0 : pready2) begin
                lat = c;
                rd  = d0 ? prdata0 : prdata2;
                err = d0 ? pslverr0 : pslverr2;
                break;
            end
        end
        @(negedge PCLK); drive(d0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        int seen;
        logic [31:0] rd; logic er; int lat;
        @(negedge PCLK); PRESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge PCLK);
        total++; if ({pready2, pslverr2, prdata2} !== 34'h0) begin bad++;
            $display("FAIL reset_outputs got=%h exp=0", {pready2, pslverr2, prdata2}); end
        total++; if ({pready0, pslverr0, prdata0} !== 34'h0) begin bad++;
            $display("FAIL reset_outputs0 got=%h exp=0", {pready0, pslverr0, prdata0}); end
        PRESET = 1'b0;
        clear_model();
        seen = 0;
        repeat (DEPTH) begin @(posedge PCLK); #1; if (pready2 || pready0) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL init_quiet got=%0d exp=0", seen); end
        xfer(1'b0, 1'b0, BASE, 32'h0, rd, er, lat);
        total++; if ({rd, er} !== 33'h0 || lat !== EW + 1) begin bad++;
            $display("FAIL clear_first got=%h/%b/%0d exp=0/0/%0d", rd, er, lat, EW + 1); end
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, rd, er, lat);
        total++; if ({rd, er} !== 33'h0 || lat !== EW + 1) begin bad++;
            $display("FAIL clear_last got=%h/%b/%0d exp=0/0/%0d", rd, er, lat, EW + 1); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        xfer(1'b0, 1'b1, BASE + 32'h8, 32'hDEADBEEF, rd, er, lat);
        ref2[2] = 32'hDEADBEEF;
        total++; if (er !== 1'b0 || lat !== EW + 1) begin bad++;
            $display("FAIL wr_resp got=%b/%0d exp=0/%0d", er, lat, EW + 1); end
        total++; if (rd !== 32'h0) begin bad++;
            $display("FAIL wr_prdata_hold got=%h exp=0", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h8, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== EW + 1) begin bad++;
            $display("FAIL rd_back got=%h/%b/%0d exp=deadbeef/0/%0d", rd, er, lat, EW + 1); end
        @(posedge PCLK); #1;
        total++; if (pready2 !== 1'b0) begin bad++; $display("FAIL pready_pulse got=%b exp=0", pready2); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        xfer(1'b0, 1'b1, BASE + 32'h40, 32'h12345678, rd, er, lat);
        total++; if (er !== 1'b1 || lat !== EW + 1) begin bad++;
            $display("FAIL err_range_wr got=%b/%0d exp=1/%0d", er, lat, EW + 1); end
        xfer(1'b0, 1'b0, BASE + 32'h2, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++;
            $display("FAIL err_misalign got=%h/%b exp=0/1", rd, er); end
        xfer(1'b0, 1'b0, BASE - 32'h4, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++;
            $display("FAIL err_below got=%h/%b exp=0/1", rd, er); end
        for (int i = 0; i < DEPTH; i++) begin
            xfer(1'b0, 1'b0, BASE + 32'(4 * i), 32'h0, rd, er, lat);
            total++; if (rd !== ref2[i] || er !== 1'b0) begin bad++;
                $display("FAIL mem_sweep[%0d] got=%h/%b exp=%h/0", i, rd, er, ref2[i]); end
        end
    endtask

    task automatic test_abort();
        int seen;
        logic [31:0] rd; logic er; int lat;
        @(negedge PCLK); drive(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h10, 32'h5);
        @(negedge PCLK); drive(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'h10, 32'h5);
        @(negedge PCLK); drive(1'b0, 1'b0, 1'b0, 1'b1, BASE + 32'h10, 32'h5);
        seen = 0;
        repeat (6) begin @(posedge PCLK); #1; if (pready2) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_pready got=%0d exp=0", seen); end
        xfer(1'b0, 1'b0, BASE + 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== ref2[4] || er !== 1'b0) begin bad++;
            $display("FAIL abort_mem got=%h/%b exp=%h/0", rd, er, ref2[4]); end
    endtask

    task automatic test_init_stall();
        int c; bit got;
        logic [31:0] rd; logic er; int lat;
        xfer(1'b0, 1'b1, BASE + 32'h4, 32'hA5A5_0001, rd, er, lat);
        @(negedge PCLK); PRESET = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK); PRESET = 1'b0;
        clear_model();
        c = 0; got = 1'b0; rd = 32'hx; er = 1'bx;
        while (!got && c < 80) begin
            @(posedge PCLK); #1; c++;
            if (pready2) begin
                got = 1'b1; rd = prdata2; er = pslverr2;
            end else begin
                @(negedge PCLK);
                if (c == 1) drive(1'b0, 1'b1, 1'b0, 1'b0, BASE + 32'h4, 32'h0);
                else if (c == 2) drive(1'b0, 1'b1, 1'b1, 1'b0, BASE + 32'h4, 32'h0);
            end
        end
        @(negedge PCLK); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (c !== DEPTH + EW + 1) begin bad++;
            $display("FAIL init_stall_latency got=%0d exp=%0d", c, DEPTH + EW + 1); end
        total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++;
            $display("FAIL init_stall_data got=%h/%b exp=0/0", rd, er); end
    endtask

    task automatic test_mid_reset();
        int seen;
        logic [31:0] rd; logic er; int lat;
        xfer(1'b0, 1'b1, BASE + 32'h14, 32'h0BAD_F00D, rd, er, lat);
        @(negedge PCLK); drive(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h18, 32'h7777_7777);
        @(negedge PCLK); drive(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'h18, 32'h7777_7777);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK); PRESET = 1'b1;
        @(posedge PCLK); #1;
        total++; if (pready2 !== 1'b0 || pslverr2 !== 1'b0) begin bad++;
            $display("FAIL mid_reset_resp got=%b/%b exp=0/0", pready2, pslverr2); end
        @(negedge PCLK); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); PRESET = 1'b0;
        clear_model();
        seen = 0;
        repeat (DEPTH) begin @(posedge PCLK); #1; if (pready2) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_init got=%0d exp=0", seen); end
        xfer(1'b0, 1'b0, BASE + 32'h14, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b0 || lat !== EW + 1) begin bad++;
            $display("FAIL mid_reset_cleared got=%h/%b/%0d exp=0/0/%0d", rd, er, lat, EW + 1); end
        xfer(1'b0, 1'b0, BASE + 32'h18, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++;
            $display("FAIL mid_reset_dropped got=%h/%b exp=0/0", rd, er); end
    endtask

    task automatic test_ew0();
        logic [31:0] rd; logic er; int lat; logic [31:0] v;
        v = $urandom;
        xfer(1'b1, 1'b1, BASE, v, rd, er, lat);
        ref0[0] = v;
        total++; if (er !== 1'b0 || lat !== 1) begin bad++;
            $display("FAIL ew0_wr got=%b/%0d exp=0/1", er, lat); end
        xfer(1'b1, 1'b0, BASE, 32'h0, rd, er, lat);
        total++; if (rd !== v || er !== 1'b0 || lat !== 1) begin bad++;
            $display("FAIL ew0_rd got=%h/%b/%0d exp=%h/0/1", rd, er, lat, v); end
        @(posedge PCLK); #1;
        total++; if (pready0 !== 1'b0) begin bad++; $display("FAIL ew0_pulse got=%b exp=0", pready0); end
        xfer(1'b1, 1'b0, BASE + 32'h40, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 1) begin bad++;
            $display("FAIL ew0_err got=%h/%b/%0d exp=0/1/1", rd, er, lat); end
    endtask

    task automatic test_random();
        logic [31:0] last [2];
        bit          have [2];
        logic [31:0] rd, addr, wd, exp_rd; logic er; int lat;
        bit d0, wr, e; int k;
        have[0] = 1'b0; have[1] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            d0 = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            k  = int'($urandom_range(0, 9));
            if (k == 0)      addr = BASE - 32'(4 * $urandom_range(1, 4));
            else if (k == 1) addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (k == 2) addr = BASE + 32'(4 * $urandom_range(16, 20));
            else             addr = BASE + 32'(4 * $urandom_range(0, 15));
            e = addr_err(addr);
            xfer(d0, wr, addr, wd, rd, er, lat);
            total++; if (er !== e || lat !== (d0 ? 1 : EW + 1)) begin bad++;
                $display("FAIL rnd_resp[%0d] a=%h got=%b/%0d exp=%b/%0d", n, addr, er, lat, e,
                         d0 ? 1 : EW + 1); end
            if (wr) begin
                if (!e && d0) ref0[widx(addr)] = wd;
                if (!e && !d0) ref2[widx(addr)] = wd;
                if (have[d0]) begin
                    total++; if (rd !== last[d0]) begin bad++;
                        $display("FAIL rnd_hold[%0d] got=%h exp=%h", n, rd, last[d0]); end
                end
            end else begin
                exp_rd = e ? 32'h0 : (d0 ? ref0[widx(addr)] : ref2[widx(addr)]);
                total++; if (rd !== exp_rd) begin bad++;
                    $display("FAIL rnd_rdata[%0d] a=%h got=%h exp=%h", n, addr, rd, exp_rd); end
                last[d0] = exp_rd; have[d0] = 1'b1;
            end
            @(posedge PCLK); #1;
            total++; if ((d0 ? pready0 : pready2) !== 1'b0) begin bad++;
                $display("FAIL rnd_pulse[%0d] got=1 exp=0", n); end
        end
    endtask

    initial begin
        PRESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_write_read();
        test_errors();
        test_abort();
        test_init_stall();
        test_mid_reset();
        test_ew0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
